// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one physical memory port between the LC-3b
// instruction and data sides; round-robin on ties, grant held until pmem_resp.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int MASK_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [MASK_W-1:0] i_mem_byte_enable,
  input  logic [ADDR_W-1:0] i_mem_address,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic              i_mem_resp,
  output logic [DATA_W-1:0] i_mem_rdata,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [MASK_W-1:0] d_mem_byte_enable,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic              d_mem_resp,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [MASK_W-1:0] pmem_byte_enable,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [DATA_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [DATA_W-1:0] pmem_rdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_I = 2'd1;
  localparam logic [1:0] GRANT_D = 2'd2;

  logic [1:0] state, next_state;
  logic       last_grant, next_last_grant;
  logic       i_pending, d_pending;

  assign i_pending = i_mem_read | i_mem_write;
  assign d_pending = d_mem_read | d_mem_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= next_state;
      last_grant <= next_last_grant;
    end
  end

  // last_grant only moves on a completed transaction; an abort leaves the tie-break alone.
  always_comb begin
    next_state      = state;
    next_last_grant = last_grant;
    case (state)
      IDLE: begin
        if (i_pending && d_pending)
          next_state = last_grant ? GRANT_I : GRANT_D;
        else if (i_pending)
          next_state = GRANT_I;
        else if (d_pending)
          next_state = GRANT_D;
      end
      GRANT_I: begin
        if (pmem_resp) begin
          next_state      = IDLE;
          next_last_grant = 1'b0;
        end else if (!i_pending) begin
          next_state = IDLE;
        end
      end
      GRANT_D: begin
        if (pmem_resp) begin
          next_state      = IDLE;
          next_last_grant = 1'b1;
        end else if (!d_pending) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Write takes priority when a requester raises read and write together.
  always_comb begin
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_byte_enable = '0;
    pmem_address     = '0;
    pmem_wdata       = '0;
    i_mem_resp       = 1'b0;
    i_mem_rdata      = '0;
    d_mem_resp       = 1'b0;
    d_mem_rdata      = '0;
    case (state)
      GRANT_I: begin
        pmem_write       = i_mem_write;
        pmem_read        = i_mem_read & ~i_mem_write;
        pmem_byte_enable = i_mem_byte_enable;
        pmem_address     = i_mem_address;
        pmem_wdata       = i_mem_wdata;
        i_mem_resp       = pmem_resp;
        i_mem_rdata      = pmem_resp ? pmem_rdata : '0;
      end
      GRANT_D: begin
        pmem_write       = d_mem_write;
        pmem_read        = d_mem_read & ~d_mem_write;
        pmem_byte_enable = d_mem_byte_enable;
        pmem_address     = d_mem_address;
        pmem_wdata       = d_mem_wdata;
        d_mem_resp       = pmem_resp;
        d_mem_rdata      = pmem_resp ? pmem_rdata : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: single transactions, round-robin
// alternation, write-over-read priority, reset mid-grant and requester withdrawal.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_mem_read, i_mem_write;
  logic [1:0]  i_mem_byte_enable;
  logic [15:0] i_mem_address, i_mem_wdata;
  logic        i_mem_resp;
  logic [15:0] i_mem_rdata;
  logic        d_mem_read, d_mem_write;
  logic [1:0]  d_mem_byte_enable;
  logic [15:0] d_mem_address, d_mem_wdata;
  logic        d_mem_resp;
  logic [15:0] d_mem_rdata;
  logic        pmem_read, pmem_write;
  logic [1:0]  pmem_byte_enable;
  logic [15:0] pmem_address, pmem_wdata;
  logic        pmem_resp;
  logic [15:0] pmem_rdata;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MASK_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .i_mem_read(i_mem_read),
    .i_mem_write(i_mem_write),
    .i_mem_byte_enable(i_mem_byte_enable),
    .i_mem_address(i_mem_address),
    .i_mem_wdata(i_mem_wdata),
    .i_mem_resp(i_mem_resp),
    .i_mem_rdata(i_mem_rdata),
    .d_mem_read(d_mem_read),
    .d_mem_write(d_mem_write),
    .d_mem_byte_enable(d_mem_byte_enable),
    .d_mem_address(d_mem_address),
    .d_mem_wdata(d_mem_wdata),
    .d_mem_resp(d_mem_resp),
    .d_mem_rdata(d_mem_rdata),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_byte_enable(pmem_byte_enable),
    .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp),
    .pmem_rdata(pmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // side 0 drives the instruction requester, side 1 the data requester
  task automatic applyStimulus(input bit side, input logic rd, input logic wr,
                               input logic [1:0] be, input logic [15:0] addr, input logic [15:0] data);
    if (!side) begin
      i_mem_read = rd; i_mem_write = wr; i_mem_byte_enable = be;
      i_mem_address = addr; i_mem_wdata = data;
    end else begin
      d_mem_read = rd; d_mem_write = wr; d_mem_byte_enable = be;
      d_mem_address = addr; d_mem_wdata = data;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_pread"}, 32'(pmem_read), 32'd0);
    checkOutput({tag, "_pwrite"}, 32'(pmem_write), 32'd0);
    checkOutput({tag, "_iresp"}, 32'(i_mem_resp), 32'd0);
    checkOutput({tag, "_dresp"}, 32'(d_mem_resp), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    pmem_resp = 1'b0;
    pmem_rdata = 16'h0;
    tick();
    tick();
    checkIdleOutputs("reset");
    checkOutput("reset_paddr", 32'(pmem_address), 32'd0);
    rst = 1'b0;

    // 1: instruction read, response three cycles into the grant
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 16'h1000, 16'h0);
    #1;
    checkOutput("t1_pread_req_cycle", 32'(pmem_read), 32'd0);
    tick();
    checkOutput("t1_pread", 32'(pmem_read), 32'd1);
    checkOutput("t1_pwrite", 32'(pmem_write), 32'd0);
    checkOutput("t1_paddr", 32'(pmem_address), 32'h1000);
    for (int k = 0; k < 2; k++) begin
      tick();
      checkOutput("t1_pread_hold", 32'(pmem_read), 32'd1);
      checkOutput("t1_iresp_early", 32'(i_mem_resp), 32'd0);
    end
    pmem_resp = 1'b1; pmem_rdata = 16'hBEEF;
    #1;
    checkOutput("t1_iresp", 32'(i_mem_resp), 32'd1);
    checkOutput("t1_irdata", 32'(i_mem_rdata), 32'hBEEF);
    checkOutput("t1_dresp", 32'(d_mem_resp), 32'd0);
    checkOutput("t1_drdata", 32'(d_mem_rdata), 32'd0);
    tick();
    pmem_resp = 1'b0; pmem_rdata = 16'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    #1;
    checkIdleOutputs("t1_after");

    // 2: data write with low byte enable
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 16'h2002, 16'h00AB);
    tick();
    checkOutput("t2_pwrite", 32'(pmem_write), 32'd1);
    checkOutput("t2_pread", 32'(pmem_read), 32'd0);
    checkOutput("t2_pbe", 32'(pmem_byte_enable), 32'h1);
    checkOutput("t2_paddr", 32'(pmem_address), 32'h2002);
    checkOutput("t2_pwdata", 32'(pmem_wdata), 32'h00AB);
    pmem_resp = 1'b1;
    #1;
    checkOutput("t2_dresp", 32'(d_mem_resp), 32'd1);
    checkOutput("t2_iresp", 32'(i_mem_resp), 32'd0);
    tick();
    pmem_resp = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    #1;
    checkIdleOutputs("t2_after");

    // 3: simultaneous requests after reset alternate I, D, I, D
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 16'h1111, 16'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 16'h2222, 16'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      checkOutput("t3_paddr", 32'(pmem_address), (k % 2 == 0) ? 32'h1111 : 32'h2222);
      pmem_resp = 1'b1; pmem_rdata = 16'h1234 + 16'(k);
      #1;
      checkOutput("t3_iresp", 32'(i_mem_resp), (k % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("t3_dresp", 32'(d_mem_resp), (k % 2 == 0) ? 32'd0 : 32'd1);
      checkOutput("t3_rdata", (k % 2 == 0) ? 32'(i_mem_rdata) : 32'(d_mem_rdata), 32'h1234 + 32'(k));
      tick();
      pmem_resp = 1'b0; pmem_rdata = 16'h0;
      #1;
      checkIdleOutputs("t3_gap");
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    tick();

    // 4: read and write together from D, write wins
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b10, 16'h3004, 16'h5500);
    tick();
    checkOutput("t4_pwrite", 32'(pmem_write), 32'd1);
    checkOutput("t4_pread", 32'(pmem_read), 32'd0);
    checkOutput("t4_pbe", 32'(pmem_byte_enable), 32'h2);
    pmem_resp = 1'b1;
    #1;
    checkOutput("t4_dresp", 32'(d_mem_resp), 32'd1);
    tick();
    pmem_resp = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    tick();

    // 5: reset in the middle of a data grant abandons it
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 16'h4000, 16'h0);
    tick();
    checkOutput("t5_pread_granted", 32'(pmem_read), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkIdleOutputs("t5_post_reset");
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    pmem_resp = 1'b1; pmem_rdata = 16'hDEAD;
    #1;
    checkOutput("t5_late_dresp", 32'(d_mem_resp), 32'd0);
    checkOutput("t5_late_iresp", 32'(i_mem_resp), 32'd0);
    checkOutput("t5_late_drdata", 32'(d_mem_rdata), 32'd0);
    tick();
    pmem_resp = 1'b0; pmem_rdata = 16'h0;

    // 6: I withdraws mid grant while D waits
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 16'h5000, 16'h0);
    tick();
    checkOutput("t6_pread_i", 32'(pmem_read), 32'd1);
    checkOutput("t6_paddr_i", 32'(pmem_address), 32'h5000);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 16'h6000, 16'h0);
    #1;
    checkOutput("t6_iresp_withdraw", 32'(i_mem_resp), 32'd0);
    tick();
    checkIdleOutputs("t6_abort_idle");
    tick();
    checkOutput("t6_pread_d", 32'(pmem_read), 32'd1);
    checkOutput("t6_paddr_d", 32'(pmem_address), 32'h6000);
    pmem_resp = 1'b1; pmem_rdata = 16'h0A0A;
    #1;
    checkOutput("t6_dresp", 32'(d_mem_resp), 32'd1);
    checkOutput("t6_drdata", 32'(d_mem_rdata), 32'h0A0A);
    tick();
    pmem_resp = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
